// File: rtl/gravity_ctrl_pkg.sv
// Shared definitions for the gravity controller: FSM state encoding and
// default timing constants used by gravity_ctrl and its period calculator.
// No ports; imported by gravity_ctrl and drop_period.
package gravity_ctrl_pkg;

  // Default timing constants (ticks)
  localparam int BASE_TICKS_DEF = 10;
  localparam int LEVEL_STEP_DEF = 1;
  localparam int MIN_TICKS_DEF  = 1;
  localparam int SOFT_TICKS_DEF = 1;
  localparam int LOCK_TICKS_DEF = 5;
  localparam int CNT_W_DEF      = 8;

  typedef enum logic [2:0] {
    ST_COUNT = 3'd0,
    ST_REQ   = 3'd1,
    ST_LOCKW = 3'd2,
    ST_LOCK  = 3'd3,
    ST_HARD  = 3'd4,
    ST_HSET  = 3'd5
  } state_e;

endpackage

// File: rtl/gravity_ctrl_drop_period.sv
// drop_period: registered gravity period from level/soft_drop.
// Ports: clk_i/rst_i clock and async reset; level_i, soft_drop_i inputs;
//        period_o = soft ? SOFT_TICKS : max(BASE_TICKS - level*LEVEL_STEP, MIN_TICKS).
module drop_period
  import gravity_ctrl_pkg::*;
#(
  parameter int BASE_TICKS = BASE_TICKS_DEF,
  parameter int LEVEL_STEP = LEVEL_STEP_DEF,
  parameter int MIN_TICKS  = MIN_TICKS_DEF,
  parameter int SOFT_TICKS = SOFT_TICKS_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [3:0]     level_i,
  input  logic           soft_drop_i,
  output logic [CNT_W:0] period_o
);

  localparam logic [CNT_W:0] BASE_W = (CNT_W+1)'(BASE_TICKS);
  localparam logic [CNT_W:0] STEP_W = (CNT_W+1)'(LEVEL_STEP);
  localparam logic [CNT_W:0] MIN_W  = (CNT_W+1)'(MIN_TICKS);
  localparam logic [CNT_W:0] SOFT_W = (CNT_W+1)'(SOFT_TICKS);
  // Period seen out of reset, matching level 0 without soft drop
  localparam logic [CNT_W:0] RST_W  = (BASE_TICKS >= MIN_TICKS) ? BASE_W : MIN_W;

  logic [CNT_W:0] dec;
  logic [CNT_W:0] diff;
  logic [CNT_W:0] period_d;
  logic [CNT_W:0] period_q;

  always_comb begin
    dec      = (CNT_W+1)'(level_i) * STEP_W;
    diff     = '0;
    period_d = MIN_W;
    if (soft_drop_i) begin
      period_d = SOFT_W;
    end else if (dec < BASE_W) begin
      // Subtraction only taken when it cannot wrap
      diff     = BASE_W - dec;
      period_d = (diff < MIN_W) ? MIN_W : diff;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) period_q <= RST_W;
    else       period_q <= period_d;
  end

  assign period_o = period_q;

endmodule

// File: rtl/gravity_ctrl.sv
// gravity_ctrl: turns game ticks into down-step requests and lock pulses.
// Inputs: clk_i, rst_i (async high), tick_i, pause_i, level_i, soft_drop_i,
//         hard_drop_i, grounded_i, down_ack_i. Outputs: down_req_o, lock_req_o, hard_rows_o.
module gravity_ctrl
  import gravity_ctrl_pkg::*;
#(
  parameter int BASE_TICKS = BASE_TICKS_DEF,
  parameter int LEVEL_STEP = LEVEL_STEP_DEF,
  parameter int MIN_TICKS  = MIN_TICKS_DEF,
  parameter int SOFT_TICKS = SOFT_TICKS_DEF,
  parameter int LOCK_TICKS = LOCK_TICKS_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tick_i,
  input  logic       pause_i,
  input  logic [3:0] level_i,
  input  logic       soft_drop_i,
  input  logic       hard_drop_i,
  input  logic       grounded_i,
  input  logic       down_ack_i,
  output logic       down_req_o,
  output logic       lock_req_o,
  output logic [4:0] hard_rows_o
);

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TICKS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic [4:0]       hard_rows_q, hard_rows_d;
  logic [CNT_W:0]   period;
  logic [CNT_W:0]   period_m1;
  logic             tick_ev;
  logic             hard_ev;

  drop_period #(
    .BASE_TICKS (BASE_TICKS),
    .LEVEL_STEP (LEVEL_STEP),
    .MIN_TICKS  (MIN_TICKS),
    .SOFT_TICKS (SOFT_TICKS),
    .CNT_W      (CNT_W)
  ) u_period (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .level_i     (level_i),
    .soft_drop_i (soft_drop_i),
    .period_o    (period)
  );

  // period is always >= 1, so this never wraps
  assign period_m1 = period - 1'b1;
  // Pause masks game inputs; the ack side of the handshake stays live
  assign tick_ev   = tick_i & ~pause_i;
  assign hard_ev   = hard_drop_i & ~pause_i;

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    lock_cnt_d  = lock_cnt_q;
    hard_rows_d = hard_rows_q;
    unique case (state_q)
      ST_COUNT: begin
        if (hard_ev) begin
          state_d     = ST_HARD;
          hard_rows_d = '0;
        end else if (tick_ev) begin
          // >= so a period that shrank below the count fires on this tick
          if ({1'b0, tick_cnt_q} >= period_m1) begin
            tick_cnt_d = '0;
            state_d    = grounded_i ? ST_LOCKW : ST_REQ;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (down_ack_i) begin
          state_d    = ST_COUNT;
          tick_cnt_d = '0;
        end
      end
      ST_LOCKW: begin
        if (hard_ev) begin
          state_d     = ST_HARD;
          hard_rows_d = '0;
        end else if (!pause_i && !grounded_i) begin
          lock_cnt_d = '0;
          tick_cnt_d = '0;
          state_d    = ST_COUNT;
        end else if (tick_ev) begin
          if (lock_cnt_q >= LOCK_LAST) state_d = ST_LOCK;
          else                         lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end
      ST_LOCK: begin
        // Held while paused so the single lock pulse is not lost
        if (!pause_i) begin
          state_d    = ST_COUNT;
          tick_cnt_d = '0;
          lock_cnt_d = '0;
        end
      end
      ST_HARD: begin
        if (grounded_i) begin
          if (!pause_i) state_d = ST_LOCK;
        end else if (down_ack_i) begin
          if (hard_rows_q != 5'd31) hard_rows_d = hard_rows_q + 1'b1;
          state_d = ST_HSET;
        end
      end
      ST_HSET: begin
        if (!pause_i) state_d = ST_HARD;
      end
      default: state_d = ST_COUNT;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_COUNT;
      tick_cnt_q  <= '0;
      lock_cnt_q  <= '0;
      hard_rows_q <= '0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      lock_cnt_q  <= lock_cnt_d;
      hard_rows_q <= hard_rows_d;
    end
  end

  // In HARD the request follows grounded so a landed piece never asks to move
  assign down_req_o  = (state_q == ST_REQ) | ((state_q == ST_HARD) & ~grounded_i);
  assign lock_req_o  = (state_q == ST_LOCK) & ~pause_i;
  assign hard_rows_o = hard_rows_q;

endmodule

// File: tb/tb_gravity_ctrl.sv
// Directed testbench for gravity_ctrl with default parameters.
// Drives inputs 1ns after the rising edge and checks outputs at that point.
// Prints one TB_RESULT summary line.
module tb_gravity_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       pause;
  logic [3:0] level;
  logic       soft_drop;
  logic       hard_drop;
  logic       grounded;
  logic       down_ack;
  logic       down_req;
  logic       lock_req;
  logic [4:0] hard_rows;

  int checks   = 0;
  int failures = 0;

  gravity_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .tick_i      (tick),
    .pause_i     (pause),
    .level_i     (level),
    .soft_drop_i (soft_drop),
    .hard_drop_i (hard_drop),
    .grounded_i  (grounded),
    .down_ack_i  (down_ack),
    .down_req_o  (down_req),
    .lock_req_o  (lock_req),
    .hard_rows_o (hard_rows)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // n ticks separated by idle cycles; returns just after the edge that took the last one
  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      if (i < n - 1) step();
    end
  endtask

  // Board acks two cycles after the request became visible
  task automatic ack_req(input string tag);
    step();
    chk({tag, "_held"}, down_req, 1);
    down_ack = 1'b1;
    step();
    down_ack = 1'b0;
    chk({tag, "_dropped"}, down_req, 0);
  endtask

  initial begin
    rst = 1'b1; tick = 0; pause = 0; level = 4'd0; soft_drop = 0;
    hard_drop = 0; grounded = 0; down_ack = 0;
    #1;
    chk("rst_down_req", down_req, 0);
    chk("rst_lock_req", lock_req, 0);
    chk("rst_hard_rows", hard_rows, 0);
    step(); step();
    rst = 1'b0;
    step();

    // 1: level 0 -> one step per 10 ticks
    tick_n(9);
    chk("t1_no_req_9", down_req, 0);
    tick_n(1);
    chk("t1_req_10", down_req, 1);
    ack_req("t1_ack_a");
    tick_n(9);
    chk("t1_no_req_19", down_req, 0);
    tick_n(1);
    chk("t1_req_20", down_req, 1);
    ack_req("t1_ack_b");

    // 2: level 12 clamps to period 1
    level = 4'd12;
    step();
    tick_n(1);
    chk("t2_clamp_a", down_req, 1);
    ack_req("t2_ack_a");
    tick_n(1);
    chk("t2_clamp_b", down_req, 1);
    ack_req("t2_ack_b");
    // period shrinks below tick_cnt -> fires on next tick
    level = 4'd0;
    step();
    tick_n(5);
    chk("t2_cnt5_no_req", down_req, 0);
    level = 4'd9;
    step();
    tick_n(1);
    chk("t2_shrink_fire", down_req, 1);
    ack_req("t2_ack_c");
    // soft drop: period 1
    level = 4'd0; soft_drop = 1'b1;
    step();
    tick_n(1);
    chk("t2_soft_fire", down_req, 1);
    ack_req("t2_ack_d");
    soft_drop = 1'b0;
    step();

    // 3: grounded at drop -> lock after 5 ticks in LOCKW
    grounded = 1'b1;
    tick_n(10);
    chk("t3_no_req_grounded", down_req, 0);
    tick_n(4);
    chk("t3_no_lock_4", lock_req, 0);
    tick_n(1);
    chk("t3_lock_pulse", lock_req, 1);
    chk("t3_lock_no_req", down_req, 0);
    step();
    chk("t3_lock_one_cycle", lock_req, 0);
    // leave ground after 3 lock ticks
    tick_n(10);
    tick_n(3);
    grounded = 1'b0;
    step();
    chk("t3_unground_no_lock", lock_req, 0);
    tick_n(9);
    chk("t3_count_restart", down_req, 0);
    tick_n(1);
    chk("t3_count_fire", down_req, 1);
    ack_req("t3_ack");

    // 4: hard drop, board grounds after 7 acks
    hard_drop = 1'b1;
    step();
    hard_drop = 1'b0;
    chk("t4_hard_rows_clr", hard_rows, 0);
    for (int k = 1; k <= 7; k++) begin
      chk($sformatf("t4_req_%0d", k), down_req, 1);
      down_ack = 1'b1;
      step();
      down_ack = 1'b0;
      chk($sformatf("t4_hset_gap_%0d", k), down_req, 0);
      chk($sformatf("t4_rows_%0d", k), hard_rows, k);
      if (k == 7) grounded = 1'b1;
      step();
    end
    chk("t4_grounded_no_req", down_req, 0);
    chk("t4_grounded_no_lock_yet", lock_req, 0);
    step();
    chk("t4_lock", lock_req, 1);
    chk("t4_rows_final", hard_rows, 7);
    step();
    chk("t4_lock_end", lock_req, 0);
    chk("t4_rows_hold", hard_rows, 7);
    // hard_drop and tick together with tick_cnt=9: hard path wins
    tick_n(9);
    tick = 1'b1; hard_drop = 1'b1;
    step();
    tick = 1'b0; hard_drop = 1'b0;
    chk("t4_coinc_rows_clr", hard_rows, 0);
    chk("t4_coinc_no_lock_yet", lock_req, 0);
    step();
    chk("t4_coinc_lock", lock_req, 1);
    step();
    grounded = 1'b0;
    chk("t4_coinc_lock_end", lock_req, 0);

    // 5: pause during REQ keeps the handshake
    tick_n(10);
    chk("t5_req", down_req, 1);
    pause = 1'b1;
    step();
    chk("t5_paused_req_held", down_req, 1);
    down_ack = 1'b1;
    step();
    down_ack = 1'b0;
    chk("t5_paused_ack", down_req, 0);
    tick_n(12);
    chk("t5_paused_ticks_ignored", down_req, 0);
    pause = 1'b0;
    step();
    tick_n(9);
    chk("t5_resume_no_req", down_req, 0);
    tick_n(1);
    chk("t5_resume_req", down_req, 1);
    ack_req("t5_ack");
    // pause at the final LOCKW tick
    grounded = 1'b1;
    tick_n(10);
    tick_n(4);
    pause = 1'b1;
    step();
    tick_n(3);
    chk("t5_paused_no_lock", lock_req, 0);
    pause = 1'b0;
    step();
    chk("t5_unpause_no_lock", lock_req, 0);
    tick_n(1);
    chk("t5_lock_after_pause", lock_req, 1);
    step();
    chk("t5_lock_end", lock_req, 0);
    grounded = 1'b0;
    step();

    // 6: reset mid-HARD with down_req high
    hard_drop = 1'b1;
    step();
    hard_drop = 1'b0;
    down_ack = 1'b1;
    step();
    down_ack = 1'b0;
    step();
    chk("t6_hard_req", down_req, 1);
    chk("t6_hard_rows1", hard_rows, 1);
    rst = 1'b1;
    #1;
    chk("t6_async_req", down_req, 0);
    chk("t6_async_lock", lock_req, 0);
    chk("t6_async_rows", hard_rows, 0);
    #1;
    rst = 1'b0;
    step();
    tick_n(9);
    chk("t6_post_no_req", down_req, 0);
    tick_n(1);
    chk("t6_post_req", down_req, 1);
    ack_req("t6_ack");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
